ahb_master_arbiter: RTL and testbench
=====================================

# ahb_master_arbiter

Shares one AHB-Lite slave path (the interconnect or SRAM port) between up to four AHB-Lite masters: the Cortex-M0 wrapper, plus loader and debug masters. Each master port has a one-entry address-phase hold stage. The arbiter chooses one held transfer per downstream address phase and tracks the data-phase owner to route write data, read data, ready and response. Masters see standard AHB-Lite wait states while their transfer is held or stalled.

## Interface
- g_masters_num, 2: number of master ports (2..4)
- g_haddr_width, 32: address width
- g_hdata_width, 32: data width
- g_arb_mode, "RR": "RR" selects round-robin; "FIXED" makes the lowest index win
- hclk_i  in  1  bus clock; all state changes on rising edge
- rst_i  in  1  asynchronous, active-high reset
- mst_haddr_i[N]  in  g_haddr_width  master address
- mst_htrans_i[N]  in  2  master HTRANS; bit 1 set = transfer request
- mst_hwrite_i[N], mst_hsize_i[N] (3), mst_hprot_i[N] (4)  in  master control
- mst_hwdata_i[N]  in  g_hdata_width  master write data
- mst_hrdata_o[N]  out  g_hdata_width  read data (hrdata_i broadcast)
- mst_hready_o[N]  out  1  per-master HREADY
- mst_hresp_o[N]  out  1  per-master HRESP
- haddr_o, htrans_o, hwrite_o, hsize_o, hprot_o  out  downstream address phase
- hburst_o  out  3  tied 3'b000 (SINGLE)
- hwdata_o  out  g_hdata_width  write data of data-phase owner
- hrdata_i, hready_i, hresp_i  in  downstream slave response
- grant_o  out  2  current address-phase owner (debug/ILA)

## Operation
- **Capture:** in a cycle with mst_hready_o[m]=1 and mst_htrans_i[m][1]=1, store haddr/hwrite/hsize/hprot in hold[m] and set pend[m].
  - SEQ is stored as NONSEQ. The downstream side only ever carries IDLE or NONSEQ.
- **Master ready:** mst_hready_o[m] = 0 while pend[m]=1. While m owns the data phase, mst_hready_o[m] = hready_i. Otherwise it is 1.
- **Master response:** mst_hresp_o[m] = hresp_i when m owns the data phase, else 0.
- **Arbitration:** runs in any cycle where the downstream address phase is not frozen. It picks the winner among pend[] and drives hold[winner] downstream with htrans_o=NONSEQ.
  - RR: search starts at last_grant+1 (cyclic).
  - FIXED: lowest pending index wins.
  - No pending transfer: htrans_o=IDLE and haddr_o/control = 0.
- **Freeze:** if htrans_o=NONSEQ and hready_i=0, the address, control and grant_o stay unchanged next cycle. This holds even when a higher-priority pend arrives.
- **Issue:** at a clock edge with hready_i=1 and htrans_o=NONSEQ:
  - clear pend[winner];
  - d_valid <= 1, d_owner <= winner;
  - last_grant <= winner.
- **Data-phase retire:** at a clock edge with hready_i=1 and nothing issued, d_valid <= 0.
- **Write data:** hwdata_o = mst_hwdata_i[d_owner] when d_valid, else 0. The master still holds hwdata because its hready is low until its data phase completes.
- **Error:** the two-cycle ERROR response is forwarded unchanged to d_owner. A pend already captured from that master is still issued.
- **Reset:** rst_i asserted at any time immediately clears pend[], d_valid and grant_o, and sets last_grant=N-1. Outputs go to htrans_o=IDLE, haddr_o=0, hwdata_o=0, all mst_hready_o=1, all mst_hresp_o=0.

## Timing
- **Single master, zero-wait:**
  - cycle 0: capture;
  - cycle 1: downstream address phase;
  - cycle 2: data phase, mst_hready_o=1, hrdata valid.
  - Next capture happens in cycle 2, so sustained throughput is 1 transfer per 2 cycles.
- **Latency:** one added cycle versus a direct connection. Each slave wait state adds one cycle.
- **Contention:** a losing master waits one extra address slot per competing transfer. RR guarantees service within N-1 slots. FIXED gives no starvation guarantee.
- **Simultaneous events:** a capture on master m and issue of hold[m] never coincide, because mst_hready_o[m]=0 while pend[m]. Issue of one master and capture on another in the same cycle is legal.
- All combinational outputs settle from registers and current-cycle slave inputs. There is no path from mst_htrans_i to htrans_o.

## Test plan
- **Single-master read:** master 0 issues NONSEQ read 0x0000_0010, zero-wait slave returns 0xDEAD_BEEF. Required: htrans_o=NONSEQ, haddr_o=0x10 in cycle 1; mst_hready_o[0]=1 with that data in cycle 2; mst_hready_o[0]=0 in cycle 1.
- **RR contention:** masters 0 and 1 request continuously (reads 0x100 and 0x200). Required: haddr_o alternates 0x100, 0x200, …, starting with master 0 after reset; grant_o toggles 0,1,0,1.
- **Wait states:** slave holds hready_i=0 for 3 cycles on write 0x2000_0004 data 0x1234_5678 while master 1 raises a request. Required: haddr_o/grant_o frozen; hwdata_o=0x1234_5678 throughout the data phase; master 1 issued on the cycle after hready_i returns high.
- **Error response:** slave gives hresp_i=1 for two cycles (hready_i 0 then 1) to master 0. Required: mst_hresp_o[0] follows hresp_i; mst_hresp_o[1]=0; mst_hready_o[0]=0 then 1.
- **Reset mid-transfer:** assert rst_i during a stalled address phase with both pends set. Required: in the same cycle htrans_o=IDLE and all mst_hready_o=1; after release, the first grant goes to master 0.
- **FIXED mode:** master 0 requests continuously and master 1 requests once. Required: master 1 is not issued while pend[0] persists, and is issued in the first slot with pend[0]=0.

Source files
------------

// File: rtl/ahb_master_arbiter.sv
// ahb_master_arbiter: shares one AHB-Lite slave path between up to four masters,
// each with a one-entry address-phase hold stage, round-robin or fixed priority.
`default_nettype none

module ahb_master_arbiter #(
  parameter int    g_masters_num = 2,
  parameter int    g_haddr_width = 32,
  parameter int    g_hdata_width = 32,
  parameter string g_arb_mode    = "RR"
) (
  input  logic                     hclk_i,
  input  logic                     rst_i,
  input  logic [g_haddr_width-1:0] mst_haddr_i  [g_masters_num],
  input  logic [1:0]               mst_htrans_i [g_masters_num],
  input  logic                     mst_hwrite_i [g_masters_num],
  input  logic [2:0]               mst_hsize_i  [g_masters_num],
  input  logic [3:0]               mst_hprot_i  [g_masters_num],
  input  logic [g_hdata_width-1:0] mst_hwdata_i [g_masters_num],
  output logic [g_hdata_width-1:0] mst_hrdata_o [g_masters_num],
  output logic                     mst_hready_o [g_masters_num],
  output logic                     mst_hresp_o  [g_masters_num],
  output logic [g_haddr_width-1:0] haddr_o,
  output logic [1:0]               htrans_o,
  output logic                     hwrite_o,
  output logic [2:0]               hsize_o,
  output logic [3:0]               hprot_o,
  output logic [2:0]               hburst_o,
  output logic [g_hdata_width-1:0] hwdata_o,
  input  logic [g_hdata_width-1:0] hrdata_i,
  input  logic                     hready_i,
  input  logic                     hresp_i,
  output logic [1:0]               grant_o
);

  localparam bit         FIXED_MODE    = (g_arb_mode == "FIXED");
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  logic [g_masters_num-1:0] pend;
  logic [g_haddr_width-1:0] hold_addr  [g_masters_num];
  logic                     hold_write [g_masters_num];
  logic [2:0]               hold_size  [g_masters_num];
  logic [3:0]               hold_prot  [g_masters_num];

  logic       d_valid;
  logic [1:0] d_owner;
  logic [1:0] last_grant;
  logic       lock;
  logic [1:0] lock_grant;

  logic       sel_valid;
  logic [1:0] sel;
  logic       issue;
  int         cand;

  logic [g_masters_num-1:0] capture;
  logic [g_masters_num-1:0] owns_data;
  logic                     unused_htrans;

  // A stalled address phase keeps its owner even if a higher-priority pend arrives.
  always_comb begin
    sel_valid = lock;
    sel       = lock_grant;
    cand      = 0;
    if (!lock) begin
      for (int i = 0; i < g_masters_num; i++) begin
        cand = FIXED_MODE ? i : (int'(last_grant) + 1 + i) % g_masters_num;
        for (int m = 0; m < g_masters_num; m++) begin
          if (!sel_valid && (m == cand) && pend[m]) begin
            sel_valid = 1'b1;
            sel       = 2'(m);
          end
        end
      end
    end
  end

  assign issue    = sel_valid && hready_i;
  assign htrans_o = sel_valid ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign grant_o  = sel_valid ? sel : 2'b00;
  assign hburst_o = 3'b000;

  always_comb begin
    haddr_o  = '0;
    hwrite_o = 1'b0;
    hsize_o  = 3'b000;
    hprot_o  = 4'b0000;
    hwdata_o = '0;
    for (int m = 0; m < g_masters_num; m++) begin
      if (sel_valid && (sel == 2'(m))) begin
        haddr_o  = hold_addr[m];
        hwrite_o = hold_write[m];
        hsize_o  = hold_size[m];
        hprot_o  = hold_prot[m];
      end
      if (owns_data[m]) begin
        hwdata_o = mst_hwdata_i[m];
      end
    end
  end

  for (genvar m = 0; m < g_masters_num; m++) begin : g_mst
    assign owns_data[m]    = d_valid && (d_owner == 2'(m));
    assign mst_hready_o[m] = pend[m] ? 1'b0 : (owns_data[m] ? hready_i : 1'b1);
    assign mst_hresp_o[m]  = owns_data[m] && hresp_i;
    assign mst_hrdata_o[m] = hrdata_i;
    assign capture[m]      = mst_hready_o[m] && mst_htrans_i[m][1];
  end

  always_comb begin
    unused_htrans = 1'b0;
    for (int m = 0; m < g_masters_num; m++) begin
      unused_htrans = unused_htrans ^ mst_htrans_i[m][0];
    end
  end

  always_ff @(posedge hclk_i or posedge rst_i) begin
    if (rst_i) begin
      pend       <= '0;
      d_valid    <= 1'b0;
      d_owner    <= 2'b00;
      last_grant <= 2'(g_masters_num - 1);
      lock       <= 1'b0;
      lock_grant <= 2'b00;
    end else begin
      for (int m = 0; m < g_masters_num; m++) begin
        if (capture[m]) begin
          pend[m] <= 1'b1;
        end else if (issue && (sel == 2'(m))) begin
          pend[m] <= 1'b0;
        end
      end
      if (issue) begin
        d_valid    <= 1'b1;
        d_owner    <= sel;
        last_grant <= sel;
      end else if (hready_i) begin
        d_valid <= 1'b0;
      end
      lock       <= sel_valid && !hready_i;
      lock_grant <= sel;
    end
  end

  // SEQ is folded into NONSEQ: only the control fields are held, htrans is implied.
  always_ff @(posedge hclk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int m = 0; m < g_masters_num; m++) begin
        hold_addr[m]  <= '0;
        hold_write[m] <= 1'b0;
        hold_size[m]  <= 3'b000;
        hold_prot[m]  <= 4'b0000;
      end
    end else begin
      for (int m = 0; m < g_masters_num; m++) begin
        if (capture[m]) begin
          hold_addr[m]  <= mst_haddr_i[m];
          hold_write[m] <= mst_hwrite_i[m];
          hold_size[m]  <= mst_hsize_i[m];
          hold_prot[m]  <= mst_hprot_i[m];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ahb_master_arbiter.sv
// Directed bench for ahb_master_arbiter: one round-robin and one fixed-priority
// instance share stimulus; expectations go through a scoreboard queue.
`default_nettype none

module tb_ahb_master_arbiter;

  localparam int N = 2;

  logic        clk;
  logic        rst;
  logic [31:0] m_haddr  [N];
  logic [1:0]  m_htrans [N];
  logic        m_hwrite [N];
  logic [2:0]  m_hsize  [N];
  logic [3:0]  m_hprot  [N];
  logic [31:0] m_hwdata [N];
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;

  logic [31:0] rr_hrdata [N];
  logic        rr_hready [N];
  logic        rr_hresp  [N];
  logic [31:0] rr_haddr;
  logic [1:0]  rr_htrans;
  logic        rr_hwrite;
  logic [2:0]  rr_hsize;
  logic [3:0]  rr_hprot;
  logic [2:0]  rr_hburst;
  logic [31:0] rr_hwdata;
  logic [1:0]  rr_grant;

  logic [31:0] fx_hrdata [N];
  logic        fx_hready [N];
  logic        fx_hresp  [N];
  logic [31:0] fx_haddr;
  logic [1:0]  fx_htrans;
  logic        fx_hwrite;
  logic [2:0]  fx_hsize;
  logic [3:0]  fx_hprot;
  logic [2:0]  fx_hburst;
  logic [31:0] fx_hwdata;
  logic [1:0]  fx_grant;

  ahb_master_arbiter #(
    .g_masters_num(N), .g_haddr_width(32), .g_hdata_width(32), .g_arb_mode("RR")
  ) dut_rr (
    .hclk_i(clk), .rst_i(rst),
    .mst_haddr_i(m_haddr), .mst_htrans_i(m_htrans), .mst_hwrite_i(m_hwrite),
    .mst_hsize_i(m_hsize), .mst_hprot_i(m_hprot), .mst_hwdata_i(m_hwdata),
    .mst_hrdata_o(rr_hrdata), .mst_hready_o(rr_hready), .mst_hresp_o(rr_hresp),
    .haddr_o(rr_haddr), .htrans_o(rr_htrans), .hwrite_o(rr_hwrite), .hsize_o(rr_hsize),
    .hprot_o(rr_hprot), .hburst_o(rr_hburst), .hwdata_o(rr_hwdata),
    .hrdata_i(hrdata), .hready_i(hready), .hresp_i(hresp), .grant_o(rr_grant)
  );

  ahb_master_arbiter #(
    .g_masters_num(N), .g_haddr_width(32), .g_hdata_width(32), .g_arb_mode("FIXED")
  ) dut_fx (
    .hclk_i(clk), .rst_i(rst),
    .mst_haddr_i(m_haddr), .mst_htrans_i(m_htrans), .mst_hwrite_i(m_hwrite),
    .mst_hsize_i(m_hsize), .mst_hprot_i(m_hprot), .mst_hwdata_i(m_hwdata),
    .mst_hrdata_o(fx_hrdata), .mst_hready_o(fx_hready), .mst_hresp_o(fx_hresp),
    .haddr_o(fx_haddr), .htrans_o(fx_htrans), .hwrite_o(fx_hwrite), .hsize_o(fx_hsize),
    .hprot_o(fx_hprot), .hburst_o(fx_hburst), .hwdata_o(fx_hwdata),
    .hrdata_i(hrdata), .hready_i(hready), .hresp_i(hresp), .grant_o(fx_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic push_exp(input string tag, input logic [63:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [63:0] obs);
    exp_t e;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%0h expected=<none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_masters();
    for (int m = 0; m < N; m++) begin
      m_htrans[m] = 2'b00;
      m_haddr[m]  = 32'h0;
      m_hwrite[m] = 1'b0;
      m_hsize[m]  = 3'b010;
      m_hprot[m]  = 4'b0011;
      m_hwdata[m] = 32'h0;
    end
    hready = 1'b1;
    hresp  = 1'b0;
    hrdata = 32'h0;
  endtask

  task automatic apply_reset();
    step();
    idle_masters();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_masters();
    #2;
    push_exp("rst_htrans", 2'b00);
    push_exp("rst_haddr", 32'h0);
    push_exp("rst_hwdata", 32'h0);
    push_exp("rst_hready0", 1'b1);
    push_exp("rst_hready1", 1'b1);
    push_exp("rst_hresp0", 1'b0);
    push_exp("rst_grant", 2'd0);
    chk(rr_htrans); chk(rr_haddr); chk(rr_hwdata);
    chk(rr_hready[0]); chk(rr_hready[1]); chk(rr_hresp[0]); chk(rr_grant);
    step();
    rst = 1'b0;

    // Single-master zero-wait read
    step();
    m_htrans[0] = 2'b10; m_haddr[0] = 32'h0000_0010;
    push_exp("rd_c0_hready0", 1'b1);
    #3 chk(rr_hready[0]);
    step();
    m_htrans[0] = 2'b00;
    push_exp("rd_c1_htrans", 2'b10);
    push_exp("rd_c1_haddr", 32'h0000_0010);
    push_exp("rd_c1_hready0", 1'b0);
    push_exp("rd_c1_grant", 2'd0);
    #3 chk(rr_htrans); chk(rr_haddr); chk(rr_hready[0]); chk(rr_grant);
    step();
    hrdata = 32'hDEAD_BEEF;
    push_exp("rd_c2_hready0", 1'b1);
    push_exp("rd_c2_hrdata0", 32'hDEAD_BEEF);
    push_exp("rd_c2_htrans", 2'b00);
    #3 chk(rr_hready[0]); chk(rr_hrdata[0]); chk(rr_htrans);

    // Round-robin contention, continuous requests from both masters
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      push_exp("rr_haddr", (k % 2 == 0) ? 32'h100 : 32'h200);
      push_exp("rr_grant", (k % 2 == 0) ? 2'd0 : 2'd1);
    end
    step();
    m_htrans[0] = 2'b10; m_haddr[0] = 32'h100;
    m_htrans[1] = 2'b10; m_haddr[1] = 32'h200;
    for (int k = 0; k < 4; k++) begin
      step();
      #3 chk(rr_haddr); chk(rr_grant);
    end

    // Slave wait states on a write while master 1 requests
    apply_reset();
    step();
    m_htrans[0] = 2'b10; m_haddr[0] = 32'h2000_0004; m_hwrite[0] = 1'b1;
    step();
    m_htrans[0] = 2'b00;
    m_htrans[1] = 2'b10; m_haddr[1] = 32'h300;
    push_exp("ws_c1_haddr", 32'h2000_0004);
    push_exp("ws_c1_grant", 2'd0);
    #3 chk(rr_haddr); chk(rr_grant);
    for (int k = 0; k < 3; k++) begin
      step();
      m_htrans[1] = 2'b00;
      m_hwdata[0] = 32'h1234_5678;
      hready = 1'b0;
      push_exp("ws_stall_haddr", 32'h300);
      push_exp("ws_stall_grant", 2'd1);
      push_exp("ws_stall_htrans", 2'b10);
      push_exp("ws_stall_hwdata", 32'h1234_5678);
      push_exp("ws_stall_hready0", 1'b0);
      push_exp("ws_stall_hready1", 1'b0);
      #3 chk(rr_haddr); chk(rr_grant); chk(rr_htrans);
      chk(rr_hwdata); chk(rr_hready[0]); chk(rr_hready[1]);
    end
    step();
    hready = 1'b1;
    push_exp("ws_c5_haddr", 32'h300);
    push_exp("ws_c5_hwdata", 32'h1234_5678);
    push_exp("ws_c5_hready0", 1'b1);
    #3 chk(rr_haddr); chk(rr_hwdata); chk(rr_hready[0]);
    step();
    m_hwdata[1] = 32'h0000_A5A5;
    push_exp("ws_c6_htrans", 2'b00);
    push_exp("ws_c6_hwdata", 32'h0000_A5A5);
    push_exp("ws_c6_hready1", 1'b1);
    #3 chk(rr_htrans); chk(rr_hwdata); chk(rr_hready[1]);

    // Two-cycle ERROR response to master 0, with a follow-on capture
    apply_reset();
    step();
    m_htrans[0] = 2'b10; m_haddr[0] = 32'h40;
    step();
    m_htrans[0] = 2'b00;
    push_exp("er_c1_hready0", 1'b0);
    #3 chk(rr_hready[0]);
    step();
    hready = 1'b0; hresp = 1'b1;
    push_exp("er_c2_hresp0", 1'b1);
    push_exp("er_c2_hresp1", 1'b0);
    push_exp("er_c2_hready0", 1'b0);
    #3 chk(rr_hresp[0]); chk(rr_hresp[1]); chk(rr_hready[0]);
    step();
    hready = 1'b1; hresp = 1'b1;
    m_htrans[0] = 2'b10; m_haddr[0] = 32'h44;
    push_exp("er_c3_hresp0", 1'b1);
    push_exp("er_c3_hresp1", 1'b0);
    push_exp("er_c3_hready0", 1'b1);
    #3 chk(rr_hresp[0]); chk(rr_hresp[1]); chk(rr_hready[0]);
    step();
    hresp = 1'b0;
    m_htrans[0] = 2'b00;
    push_exp("er_c4_hresp0", 1'b0);
    push_exp("er_c4_htrans", 2'b10);
    push_exp("er_c4_haddr", 32'h44);
    #3 chk(rr_hresp[0]); chk(rr_htrans); chk(rr_haddr);

    // Reset during a stalled address phase with both pends set
    apply_reset();
    step();
    m_htrans[0] = 2'b10; m_haddr[0] = 32'h100;
    m_htrans[1] = 2'b10; m_haddr[1] = 32'h200;
    step();
    hready = 1'b0;
    push_exp("mr_stall_htrans", 2'b10);
    push_exp("mr_stall_grant", 2'd0);
    #3 chk(rr_htrans); chk(rr_grant);
    step();
    #2 rst = 1'b1;
    push_exp("mr_rst_htrans", 2'b00);
    push_exp("mr_rst_haddr", 32'h0);
    push_exp("mr_rst_hready0", 1'b1);
    push_exp("mr_rst_hready1", 1'b1);
    #1 chk(rr_htrans); chk(rr_haddr); chk(rr_hready[0]); chk(rr_hready[1]);
    step();
    rst = 1'b0;
    hready = 1'b1;
    step();
    push_exp("mr_after_grant", 2'd0);
    push_exp("mr_after_haddr", 32'h100);
    push_exp("mr_after_htrans", 2'b10);
    #3 chk(rr_grant); chk(rr_haddr); chk(rr_htrans);

    // FIXED: master 0 continuous, master 1 once, with a stalled first slot
    apply_reset();
    step();
    m_htrans[0] = 2'b10; m_haddr[0] = 32'h100;
    m_htrans[1] = 2'b10; m_haddr[1] = 32'h200;
    step();
    m_htrans[1] = 2'b00;
    hready = 1'b0;
    push_exp("fx_c1_haddr", 32'h100); push_exp("fx_c1_grant", 2'd0);
    #3 chk(fx_haddr); chk(fx_grant);
    step();
    push_exp("fx_c2_haddr", 32'h100); push_exp("fx_c2_grant", 2'd0);
    #3 chk(fx_haddr); chk(fx_grant);
    step();
    hready = 1'b1;
    push_exp("fx_c3_haddr", 32'h100); push_exp("fx_c3_grant", 2'd0);
    #3 chk(fx_haddr); chk(fx_grant);
    step();
    push_exp("fx_c4_haddr", 32'h200); push_exp("fx_c4_grant", 2'd1);
    #3 chk(fx_haddr); chk(fx_grant);
    step();
    push_exp("fx_c5_haddr", 32'h100); push_exp("fx_c5_grant", 2'd0);
    #3 chk(fx_haddr); chk(fx_grant);

    // FIXED: stalled master 1 keeps the bus when master 0 arrives
    apply_reset();
    step();
    m_htrans[1] = 2'b10; m_haddr[1] = 32'h200;
    step();
    m_htrans[1] = 2'b00;
    m_htrans[0] = 2'b10; m_haddr[0] = 32'h100;
    hready = 1'b0;
    push_exp("fz_c1_haddr", 32'h200); push_exp("fz_c1_grant", 2'd1);
    #3 chk(fx_haddr); chk(fx_grant);
    step();
    m_htrans[0] = 2'b00;
    hready = 1'b1;
    push_exp("fz_c2_haddr", 32'h200); push_exp("fz_c2_grant", 2'd1);
    #3 chk(fx_haddr); chk(fx_grant);
    step();
    push_exp("fz_c3_haddr", 32'h100); push_exp("fz_c3_grant", 2'd0);
    #3 chk(fx_haddr); chk(fx_grant);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
